// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared opcodes, FSM states and requester-select type for the
//                SPI/host RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef enum logic {
        SEL_HOST = 1'b0,
        SEL_SPI  = 1'b1
    } req_sel_e;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [7:0] data;
    } spi_pend_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester arbiter (SPI vs host) with a last-grant bit;
//                round-robin or fixed SPI priority selected by RR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import spi_ram_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     req_spi,
    input  logic     req_host,
    input  logic     grant,
    output logic     valid,
    output req_sel_e winner
);

    req_sel_e last_q;
    req_sel_e last_d;

    always_comb begin
        valid = req_spi | req_host;
        if (req_spi && req_host) begin
            winner = (RR_EN && (last_q == SEL_SPI)) ? SEL_HOST : SEL_SPI;
        end else if (req_spi) begin
            winner = SEL_SPI;
        end else begin
            winner = SEL_HOST;
        end
        last_d = (grant && valid) ? winner : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SEL_HOST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_arbiter
//  Description : Decodes SPI commands, holds address registers and shares the
//                single-port RAM between SPI and a local host requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic [7:0] host_rdata,
    output logic       host_rvalid,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       spi_ovf
);

    state_e     state_q,     state_d;
    req_sel_e   owner_q,     owner_d;
    spi_pend_t  pend_q,      pend_d;
    logic [7:0] wr_addr_q,   wr_addr_d;
    logic [7:0] rd_addr_q,   rd_addr_d;
    logic       ovf_q,       ovf_d;
    logic       ram_en_q,    ram_en_d;
    logic       ram_we_q,    ram_we_d;
    logic [7:0] ram_addr_q,  ram_addr_d;
    logic [7:0] ram_wdata_q, ram_wdata_d;
    logic       host_gnt_q,  host_gnt_d;
    logic       tx_valid_q,  tx_valid_d;
    logic [7:0] tx_data_q,   tx_data_d;
    logic       host_rv_q,   host_rv_d;
    logic [7:0] host_rd_q,   host_rd_d;

    logic       arb_valid;
    req_sel_e   arb_winner;
    logic [1:0] rx_op;
    logic [7:0] rx_payload;

    assign rx_op      = rx_data[9:8];
    assign rx_payload = rx_data[7:0];

    rr_arbiter2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_spi  (pend_q.valid),
        .req_host (host_req),
        .grant    (state_q == ST_IDLE),
        .valid    (arb_valid),
        .winner   (arb_winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pend_d      = pend_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        ovf_d       = ovf_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        host_gnt_d  = 1'b0;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        host_rv_d   = 1'b0;
        host_rd_d   = host_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d  = arb_winner;
                    ram_en_d = 1'b1;
                    if (arb_winner == SEL_SPI) begin
                        ram_we_d    = pend_q.we;
                        ram_addr_d  = pend_q.we ? wr_addr_q : rd_addr_q;
                        ram_wdata_d = pend_q.data;
                    end else begin
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                        host_gnt_d  = 1'b1;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (owner_q == SEL_SPI) begin
                    pend_d.valid = 1'b0;
                end
                state_d = ram_we_q ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (owner_q == SEL_SPI) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = ram_rdata;
                end else begin
                    host_rv_d = 1'b1;
                    host_rd_d = ram_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decode after the FSM so a command meeting a still-set pending slot
        // is dropped even in the cycle that slot is being released.
        if (rx_valid) begin
            case (rx_op)
                OP_WR_ADDR: wr_addr_d = rx_payload;
                OP_RD_ADDR: rd_addr_d = rx_payload;
                default: begin
                    if (pend_q.valid) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d.valid = 1'b1;
                        pend_d.we    = (rx_op == OP_WR_DATA);
                        pend_d.data  = rx_payload;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= SEL_HOST;
            pend_q      <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            ovf_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            host_gnt_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            host_rv_q   <= 1'b0;
            host_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pend_q      <= pend_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            ovf_q       <= ovf_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            host_gnt_q  <= host_gnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            host_rv_q   <= host_rv_d;
            host_rd_q   <= host_rd_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_gnt    = host_gnt_q;
    assign host_rdata  = host_rd_q;
    assign host_rvalid = host_rv_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign spi_ovf     = ovf_q;

endmodule
`default_nettype wire
